// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and 4-state sequencer guarding one shared DATA_W-bit register.
// One transaction (write or read) runs at a time; rdata returns the post-access value.
module shared_reg_arbiter #(
   parameter int unsigned          NUM_REQ   = 4,
   parameter int unsigned          DATA_W    = 32,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          we,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata_flat,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        done,
   output logic [DATA_W-1:0]           rdata,
   output logic                        busy,
   output logic [DATA_W-1:0]           reg_q
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StGrant  = 2'd1,
      StAccess = 2'd2,
      StDone   = 2'd3
   } state_e;

   state_e              state_q;
   logic [IdxW-1:0]     idx_q;
   logic [IdxW-1:0]     last_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic                done_q;
   logic                busy_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   shared_q;

   logic                win_found;
   logic [IdxW-1:0]     win_idx;
   int unsigned         cand;

   // Scan upward from the requester after the last winner, wrapping, so the last
   // winner itself is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(last_q) + k) % NUM_REQ;
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = IdxW'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         last_q   <= IdxW'(NUM_REQ - 1);
         we_q     <= 1'b0;
         wdata_q  <= '0;
         gnt_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         rdata_q  <= '0;
         shared_q <= RESET_VAL;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (win_found) begin
                  idx_q   <= win_idx;
                  we_q    <= we[win_idx];
                  wdata_q <= wdata_flat[win_idx*DATA_W +: DATA_W];
                  gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                  busy_q  <= 1'b1;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               state_q <= StAccess;
            end
            StAccess: begin
               if (we_q) begin
                  shared_q <= wdata_q;
                  rdata_q  <= wdata_q;
               end else begin
                  rdata_q  <= shared_q;
               end
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               last_q  <= idx_q;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign busy  = busy_q;
   assign reg_q = shared_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: expected grant/rdata/reg_q pushed at issue,
// popped and compared on every done pulse.
module tb_shared_reg_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req;
   logic [N-1:0]      we;
   logic [N*W-1:0]    wdata_flat;
   logic [N-1:0]      gnt;
   logic              done;
   logic [W-1:0]      rdata;
   logic              busy;
   logic [W-1:0]      reg_q;

   shared_reg_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (W),
      .RESET_VAL ('0)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .we         (we),
      .wdata_flat (wdata_flat),
      .gnt        (gnt),
      .done       (done),
      .rdata      (rdata),
      .busy       (busy),
      .reg_q      (reg_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] gnt;
      logic [W-1:0] rdata;
      logic [W-1:0] regv;
   } exp_t;

   exp_t         sb_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           done_cnt = 0;
   logic [W-1:0] m_reg;
   int unsigned  m_last;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned rr_pick(input logic [N-1:0] mask, input int unsigned last);
      for (int unsigned k = 1; k <= N; k++) begin
         if (mask[(last + k) % N]) return (last + k) % N;
      end
      return 0;
   endfunction

   // Model one transaction issued while the DUT is idle.
   task automatic model_issue(input logic [N-1:0] mask, input logic [N-1:0] wmask,
                              input logic [N*W-1:0] wd);
      int unsigned w;
      exp_t e;
      w = rr_pick(mask, m_last);
      if (wmask[w]) m_reg = wd[w*W +: W];
      e.gnt   = N'(1) << w;
      e.rdata = m_reg;
      e.regv  = m_reg;
      sb_q.push_back(e);
      m_last = w;
   endtask

   always @(negedge clk) begin
      if (!reset && busy) check_val("gnt_onehot", W'($onehot(gnt)), W'(1));
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", W'(1), W'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("done_gnt", W'(gnt), W'(e.gnt));
            check_val("done_rdata", rdata, e.rdata);
            check_val("done_reg_q", reg_q, e.regv);
         end
         done_cnt++;
      end
   end

   task automatic wait_done(input int n);
      int target;
      target = done_cnt + n;
      for (int c = 0; c < 40 * n; c++) begin
         @(posedge clk);
         if (done_cnt >= target) break;
      end
      if (done_cnt < target) check_val("done_timeout", W'(done_cnt), W'(target));
   endtask

   // Issue, drop req and scramble we/wdata once granted, then wait for completion.
   task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] wmask,
                          input logic [N*W-1:0] wd);
      @(negedge clk);
      req = mask; we = wmask; wdata_flat = wd;
      model_issue(mask, wmask, wd);
      @(posedge clk);
      @(negedge clk);
      req = '0; we = ~wmask; wdata_flat = ~wd;
      wait_done(1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req = '0; we = '0; wdata_flat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_reg = '0; m_last = N - 1;
   endtask

   initial begin
      logic [N*W-1:0] wd;
      int             cnt0;
      reset = 1'b1; req = '0; we = '0; wdata_flat = '0;
      m_reg = '0; m_last = N - 1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_gnt", W'(gnt), '0);
      check_val("rst_done", W'(done), '0);
      check_val("rst_busy", W'(busy), '0);
      check_val("rst_rdata", rdata, '0);
      check_val("rst_reg_q", reg_q, '0);
      reset = 1'b0;

      // Single write with cycle-level latency checks
      @(negedge clk);
      wd = '0; wd[2*W +: W] = 32'h7B;
      req = 4'b0100; we = 4'b0100; wdata_flat = wd;
      model_issue(4'b0100, 4'b0100, wd);
      @(negedge clk);
      check_val("t2_gnt_c1", W'(gnt), W'(4'b0100));
      check_val("t2_busy_c1", W'(busy), W'(1));
      check_val("t2_done_c1", W'(done), W'(0));
      req = '0;
      @(negedge clk);
      check_val("t2_gnt_c2", W'(gnt), W'(4'b0100));
      check_val("t2_reg_c2", reg_q, '0);
      @(negedge clk);
      check_val("t2_done_c3", W'(done), W'(1));
      check_val("t2_reg_c3", reg_q, 32'h7B);
      @(negedge clk);
      check_val("t2_gnt_c4", W'(gnt), '0);
      check_val("t2_busy_c4", W'(busy), '0);
      check_val("t2_done_c4", W'(done), '0);

      // Read back
      run_txn(4'b0010, 4'b0000, '0);
      check_val("t3_reg_q", reg_q, 32'h7B);

      // Contention: all write, req held for five grants
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) wd[i*W +: W] = 32'h10 + W'(i);
      req = 4'b1111; we = 4'b1111; wdata_flat = wd;
      for (int i = 0; i < 5; i++) model_issue(4'b1111, 4'b1111, wd);
      wait_done(5);
      @(negedge clk);
      req = '0; we = '0;
      repeat (3) @(negedge clk);
      check_val("t4_idle_busy", W'(busy), '0);
      check_val("t4_reg_q", reg_q, 32'h10);

      // Reset aborts a write during GRANT
      @(negedge clk);
      wd = '0; wd[0 +: W] = 32'hDEAD;
      req = 4'b0001; we = 4'b0001; wdata_flat = wd;
      @(negedge clk);
      check_val("t5_gnt_granted", W'(gnt), W'(4'b0001));
      cnt0 = done_cnt;
      reset = 1'b1; req = '0;
      @(negedge clk);
      reset = 1'b0;
      check_val("t5_gnt", W'(gnt), '0);
      check_val("t5_busy", W'(busy), '0);
      check_val("t5_reg_q", reg_q, '0);
      m_reg = '0; m_last = N - 1;
      repeat (4) @(negedge clk);
      check_val("t5_no_done", W'(done_cnt), W'(cnt0));
      check_val("t5_reg_q_after", reg_q, '0);

      // Drop req during GRANT; changes to we/wdata after grant are ignored
      wd = '0; wd[3*W +: W] = 32'h55;
      run_txn(4'b1000, 4'b1000, wd);
      check_val("t6_reg_q", reg_q, 32'h55);

      // Mixed masks exercise round-robin rotation
      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] m, wm;
         m  = N'($urandom_range(1, 15));
         wm = N'($urandom_range(0, 15));
         for (int j = 0; j < N; j++) wd[j*W +: W] = $urandom;
         run_txn(m, wm, wd);
      end

      repeat (3) @(negedge clk);
      check_val("sb_drained", W'(sb_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
